// File: rtl/tpu_axi_rd_arb.sv
// AXI read arbiter: NREQ requesters share one AXI read port, one burst at a time.
// Define TPU_AXI_RD_ARB_RR_EN for round-robin arbitration (default: fixed priority).
module tpu_axi_rd_arb #(
  parameter int NREQ   = 3,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_vld,
  output logic [NREQ-1:0]        req_rdy,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*8-1:0]      req_len,
  output logic [NREQ-1:0]        rsp_vld,
  input  logic [NREQ-1:0]        rsp_rdy,
  output logic [DATA_W-1:0]      rsp_data,
  output logic                   rsp_last,
  output logic [ID_W-1:0]        ARID,
  output logic [ADDR_W-1:0]      ARADDR,
  output logic [7:0]             ARLEN,
  output logic [2:0]             ARSIZE,
  output logic [1:0]             ARBURST,
  output logic [3:0]             ARREGION,
  output logic                   ARVALID,
  input  logic                   ARREADY,
  input  logic [ID_W-1:0]        RID,
  input  logic [DATA_W-1:0]      RDATA,
  input  logic [1:0]             RRESP,
  input  logic                   RLAST,
  input  logic                   RVALID,
  output logic                   RREADY,
  output logic                   err
);

  localparam logic [2:0] C_SIZE = 3'($clog2(DATA_W / 8));

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA
  } state_t;

  state_t              r_state;
  state_t              w_nxt;
  logic [ID_W-1:0]     r_grant;
  logic [NREQ-1:0]     r_goh;
  logic [ADDR_W-1:0]   r_araddr;
  logic [7:0]          r_arlen;
  logic [2:0]          r_arsize;
  logic [1:0]          r_arburst;
  logic [7:0]          r_cnt;
  logic                r_err;

  logic                w_any;
  logic [ID_W-1:0]     w_gid;
  logic [NREQ-1:0]     w_goh;
  logic [ADDR_W-1:0]   w_addr;
  logic [7:0]          w_len;
  logic                w_ar_hs;
  logic                w_beat;
  logic                w_bad;

`ifdef TPU_AXI_RD_ARB_RR_EN
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  logic [GW-1:0]       r_ptr;
`endif

  assign w_any   = |req_vld;
  assign w_ar_hs = (r_state == S_ADDR) && ARREADY;
  assign w_beat  = (r_state == S_DATA) && RVALID && RREADY;

  // Lowest index wins; round-robin then overrides with the lowest index at or above the pointer.
  always_comb begin
    w_gid  = '0;
    w_goh  = '0;
    w_addr = '0;
    w_len  = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_vld[i]) begin
        w_gid    = ID_W'(i);
        w_goh    = '0;
        w_goh[i] = 1'b1;
        w_addr   = req_addr[i*ADDR_W +: ADDR_W];
        w_len    = req_len[i*8 +: 8];
      end
    end
`ifdef TPU_AXI_RD_ARB_RR_EN
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_vld[i] && (i >= int'(r_ptr))) begin
        w_gid    = ID_W'(i);
        w_goh    = '0;
        w_goh[i] = 1'b1;
        w_addr   = req_addr[i*ADDR_W +: ADDR_W];
        w_len    = req_len[i*8 +: 8];
      end
    end
`endif
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_any) w_nxt = S_ADDR;
      S_ADDR:  if (ARREADY) w_nxt = S_DATA;
      S_DATA:  if (w_beat && RLAST) w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  assign w_bad = (RRESP != 2'b00) || (RID != r_grant) ||
                 (RLAST && (r_cnt != r_arlen)) ||
                 (!RLAST && (r_cnt == r_arlen));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_grant   <= '0;
      r_goh     <= '0;
      r_araddr  <= '0;
      r_arlen   <= '0;
      r_arsize  <= '0;
      r_arburst <= '0;
      r_cnt     <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if ((r_state == S_IDLE) && w_any) begin
        r_grant   <= w_gid;
        r_goh     <= w_goh;
        r_araddr  <= w_addr;
        r_arlen   <= w_len;
        r_arsize  <= C_SIZE;
        r_arburst <= 2'b01;
      end
      if (w_ar_hs) r_cnt <= '0;
      else if (w_beat) r_cnt <= r_cnt + 8'd1;
      if (w_beat && w_bad) r_err <= 1'b1;
    end
  end

`ifdef TPU_AXI_RD_ARB_RR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_ar_hs) begin
      if (r_grant == ID_W'(NREQ - 1)) r_ptr <= '0;
      else r_ptr <= GW'(r_grant + 1'b1);
    end
  end
`endif

  assign ARVALID  = (r_state == S_ADDR);
  assign ARID     = r_grant;
  assign ARADDR   = r_araddr;
  assign ARLEN    = r_arlen;
  assign ARSIZE   = r_arsize;
  assign ARBURST  = r_arburst;
  assign ARREGION = 4'b0;
  assign err      = r_err;

  assign req_rdy  = w_ar_hs ? r_goh : '0;
  assign rsp_vld  = ((r_state == S_DATA) && RVALID) ? r_goh : '0;
  assign RREADY   = (r_state == S_DATA) && |(rsp_rdy & r_goh);
  assign rsp_data = (r_state == S_DATA) ? RDATA : '0;
  assign rsp_last = (r_state == S_DATA) && RLAST;

endmodule
